// File: rtl/pbit_anneal_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pbit_anneal_scheduler_pkg
// Shared definitions for the p-bit annealing scheduler and the MAC array:
//   - I0_WIDTH : width of the broadcast I_0 scaling value (fixed point [2][2])
//   - state_t  : scheduler FSM state encoding
//   - cnt_width: counter width helper (clog2 with a floor of one bit)
// -----------------------------------------------------------------------------
package pbit_anneal_scheduler_pkg;

    localparam int I0_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bits needed to hold 0..count-1; a single-value counter still gets one bit.
    function automatic int cnt_width(input int count);
        int width;
        if (count <= 1) begin
            width = 1;
        end else begin
            width = $clog2(count);
        end
        return width;
    endfunction

endpackage

// File: rtl/pbit_anneal_scheduler_if.sv
// -----------------------------------------------------------------------------
// pbit_anneal_scheduler_if
// Run-control and p-bit array signals of the annealing scheduler.
//   start     : single-cycle pulse that begins a run (ignored while busy)
//   abort     : synchronous stop, wins over start
//   I_0       : I0_WIDTH-bit scaling value broadcast to every mac instance
//   update_en : N_PBITS-bit one-hot (or zero) latch enable for the p-bits
//   busy      : high while a run is in progress
//   done      : one-cycle pulse at normal completion
// Modports:
//   master : run controller side (drives start/abort, observes the rest)
//   slave  : scheduler side
// -----------------------------------------------------------------------------
interface pbit_anneal_scheduler_if
    import pbit_anneal_scheduler_pkg::*;
#(
    parameter int N_PBITS = 4
);

    logic                 start;
    logic                 abort;
    logic [I0_WIDTH-1:0]  I_0;
    logic [N_PBITS-1:0]   update_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output abort,
        input  I_0,
        input  update_en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        output I_0,
        output update_en,
        output busy,
        output done
    );

endinterface

// File: rtl/pbit_anneal_scheduler.sv
// -----------------------------------------------------------------------------
// pbit_anneal_scheduler
// Sequences Gibbs-style updates over N_PBITS p-bits: each p-bit gets one
// update_en pulse after a settle window of SETTLE_CYCLES idle cycles, p-bits
// are visited in index order, SWEEPS_PER_STEP full sweeps are made per I_0
// value, and I_0 ramps linearly from I0_START to I0_MAX.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pbit_anneal_scheduler_if.slave (start, abort, I_0, update_en,
//           busy, done)
//
// All outputs are registered. The output registers are loaded from the
// next-state values, so each output changes on the same edge as the state
// that it describes.
// -----------------------------------------------------------------------------
module pbit_anneal_scheduler
    import pbit_anneal_scheduler_pkg::*;
#(
    parameter int                  N_PBITS         = 4,
    parameter int                  SETTLE_CYCLES   = 2,
    parameter int                  SWEEPS_PER_STEP = 4,
    parameter logic [I0_WIDTH-1:0] I0_START        = 4'd0,
    parameter logic [I0_WIDTH-1:0] I0_MAX          = 4'd15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pbit_anneal_scheduler_if.slave  bus
);

    localparam int IDX_W    = cnt_width(N_PBITS);
    localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
    localparam int SWEEP_W  = cnt_width(SWEEPS_PER_STEP);

    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_PBITS - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_ZERO    = {IDX_W{1'b0}};
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
    localparam logic [SWEEP_W-1:0]  SWEEP_LAST  = SWEEP_W'(SWEEPS_PER_STEP - 1);
    localparam logic [SWEEP_W-1:0]  SWEEP_ONE   = SWEEP_W'(1);
    localparam logic [SWEEP_W-1:0]  SWEEP_ZERO  = {SWEEP_W{1'b0}};
    localparam logic [I0_WIDTH-1:0] I0_ONE      = {{(I0_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [N_PBITS-1:0]  EN_BIT0     = {{(N_PBITS - 1){1'b0}}, 1'b1};
    localparam logic [N_PBITS-1:0]  EN_NONE     = {N_PBITS{1'b0}};

    // State and counters
    state_t                state_r;
    state_t                state_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_s;
    logic [SETTLE_W-1:0]   settle_cnt_r;
    logic [SETTLE_W-1:0]   settle_cnt_s;
    logic [SWEEP_W-1:0]    sweep_cnt_r;
    logic [SWEEP_W-1:0]    sweep_cnt_s;

    // Registered outputs and their next values
    logic [I0_WIDTH-1:0]   i0_r;
    logic [I0_WIDTH-1:0]   i0_s;
    logic [N_PBITS-1:0]    update_en_r;
    logic [N_PBITS-1:0]    update_en_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  done_r;
    logic                  done_s;

    // State register: FSM state and sequencing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= IDX_ZERO;
            settle_cnt_r <= SETTLE_ZERO;
            sweep_cnt_r  <= SWEEP_ZERO;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            settle_cnt_r <= settle_cnt_s;
            sweep_cnt_r  <= sweep_cnt_s;
        end
    end

    // Next-state logic: walk settle -> update per p-bit, sweep and step rollovers,
    // and the I_0 ramp, which only moves at a step end.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        settle_cnt_s = settle_cnt_r;
        sweep_cnt_s  = sweep_cnt_r;
        i0_s         = i0_r;

        case (state_r)
            IDLE: begin
                // abort in the same cycle as start keeps the scheduler idle
                if (bus.start && !bus.abort) begin
                    state_s      = SETTLE;
                    idx_s        = IDX_ZERO;
                    settle_cnt_s = SETTLE_ZERO;
                    sweep_cnt_s  = SWEEP_ZERO;
                    i0_s         = I0_START;
                end else begin
                    state_s = IDLE;
                end
            end

            SETTLE: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    settle_cnt_s = SETTLE_ZERO;
                    state_s      = UPDATE;
                end else begin
                    settle_cnt_s = settle_cnt_r + SETTLE_ONE;
                    state_s      = SETTLE;
                end
            end

            UPDATE: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (idx_r != IDX_LAST) begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = SETTLE;
                end else begin
                    idx_s = IDX_ZERO;
                    if (sweep_cnt_r != SWEEP_LAST) begin
                        sweep_cnt_s = sweep_cnt_r + SWEEP_ONE;
                        state_s     = SETTLE;
                    end else begin
                        sweep_cnt_s = SWEEP_ZERO;
                        // Increment only below I0_MAX, so I_0 can never wrap.
                        if (i0_r == I0_MAX) begin
                            state_s = DONE;
                        end else begin
                            i0_s    = i0_r + I0_ONE;
                            state_s = SETTLE;
                        end
                    end
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with
    // the state they belong to; update_en is the inline one-hot decode of idx.
    always_comb begin
        update_en_s = EN_NONE;
        busy_s      = 1'b0;
        done_s      = 1'b0;

        case (state_s)
            IDLE: begin
                update_en_s = EN_NONE;
                busy_s      = 1'b0;
                done_s      = 1'b0;
            end
            SETTLE: begin
                update_en_s = EN_NONE;
                busy_s      = 1'b1;
                done_s      = 1'b0;
            end
            UPDATE: begin
                update_en_s = EN_BIT0 << idx_s;
                busy_s      = 1'b1;
                done_s      = 1'b0;
            end
            DONE: begin
                update_en_s = EN_NONE;
                busy_s      = 1'b0;
                done_s      = 1'b1;
            end
            default: begin
                update_en_s = EN_NONE;
                busy_s      = 1'b0;
                done_s      = 1'b0;
            end
        endcase
    end

    // Output registers, including the I_0 ramp value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_r        <= I0_START;
            update_en_r <= EN_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            i0_r        <= i0_s;
            update_en_r <= update_en_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.I_0       = i0_r;
    assign bus.update_en = update_en_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_pbit_anneal_scheduler.sv
module tb_pbit_anneal_scheduler;
    import pbit_anneal_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main configuration: N=4, S=2, SWEEPS=2, I_0 13..15 -> U=24, done at t+72
    pbit_anneal_scheduler_if #(.N_PBITS(4)) bus_a ();
    // Degenerate configuration: N=2, S=1, SWEEPS=1, I_0 15..15 -> done at t+4
    pbit_anneal_scheduler_if #(.N_PBITS(2)) bus_b ();

    pbit_anneal_scheduler #(
        .N_PBITS(4), .SETTLE_CYCLES(2), .SWEEPS_PER_STEP(2),
        .I0_START(4'd13), .I0_MAX(4'd15)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    pbit_anneal_scheduler #(
        .N_PBITS(2), .SETTLE_CYCLES(1), .SWEEPS_PER_STEP(1),
        .I0_START(4'd15), .I0_MAX(4'd15)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        int         cyc;   // cycles after the start edge t
        logic [3:0] en;
        logic [3:0] i0;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vec_a[$];
    vec_t vec_b[$];

    logic [3:0] cap_en   [0:79];
    logic [3:0] cap_i0   [0:79];
    logic       cap_busy [0:79];
    logic       cap_done [0:79];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check($sformatf("%s c%0d update_en", tag, v.cyc), {28'd0, cap_en[v.cyc]}, {28'd0, v.en});
        check($sformatf("%s c%0d I_0", tag, v.cyc), {28'd0, cap_i0[v.cyc]}, {28'd0, v.i0});
        check($sformatf("%s c%0d busy", tag, v.cyc), {31'd0, cap_busy[v.cyc]}, {31'd0, v.busy});
        check($sformatf("%s c%0d done", tag, v.cyc), {31'd0, cap_done[v.cyc]}, {31'd0, v.done});
    endtask

    initial begin
        logic [3:0] exp_en;
        int         bad;

        // Hand-computed checkpoints of the main full run (t = start edge).
        vec_a.push_back('{0,  4'b0000, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{1,  4'b0000, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{2,  4'b0001, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{3,  4'b0000, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{5,  4'b0010, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{8,  4'b0100, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{11, 4'b1000, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{23, 4'b1000, 4'd13, 1'b1, 1'b0});
        vec_a.push_back('{24, 4'b0000, 4'd14, 1'b1, 1'b0});
        vec_a.push_back('{26, 4'b0001, 4'd14, 1'b1, 1'b0});
        vec_a.push_back('{32, 4'b0100, 4'd14, 1'b1, 1'b0});
        vec_a.push_back('{47, 4'b1000, 4'd14, 1'b1, 1'b0});
        vec_a.push_back('{48, 4'b0000, 4'd15, 1'b1, 1'b0});
        vec_a.push_back('{71, 4'b1000, 4'd15, 1'b1, 1'b0});
        vec_a.push_back('{72, 4'b0000, 4'd15, 1'b0, 1'b1});
        vec_a.push_back('{73, 4'b0000, 4'd15, 1'b0, 1'b0});

        // Degenerate run checkpoints.
        vec_b.push_back('{0, 4'b0000, 4'd15, 1'b1, 1'b0});
        vec_b.push_back('{1, 4'b0001, 4'd15, 1'b1, 1'b0});
        vec_b.push_back('{2, 4'b0000, 4'd15, 1'b1, 1'b0});
        vec_b.push_back('{3, 4'b0010, 4'd15, 1'b1, 1'b0});
        vec_b.push_back('{4, 4'b0000, 4'd15, 1'b0, 1'b1});
        vec_b.push_back('{5, 4'b0000, 4'd15, 1'b0, 1'b0});

        rst_n       = 1'b0;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset update_en", {28'd0, bus_a.update_en}, 32'd0);
        check("reset busy", {31'd0, bus_a.busy}, 32'd0);
        check("reset done", {31'd0, bus_a.done}, 32'd0);
        check("reset I_0 a", {28'd0, bus_a.I_0}, 32'd13);
        check("reset I_0 b", {28'd0, bus_b.I_0}, 32'd15);

        rst_n = 1'b1;
        @(negedge clk);

        // Full run; a stray start at c=30 must be ignored, and a start in the
        // first IDLE cycle after done (c=73) begins a back-to-back run.
        bus_a.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 74; c++) begin
            cap_en[c]   = bus_a.update_en;
            cap_i0[c]   = bus_a.I_0;
            cap_busy[c] = bus_a.busy;
            cap_done[c] = bus_a.done;
            exp_en = 4'b0000;
            if (c >= 2 && c < 72 && ((c - 2) % 3) == 0) begin
                exp_en = 4'b0001 << (((c - 2) / 3) % 4);
            end
            check($sformatf("schedule c%0d", c), {28'd0, bus_a.update_en}, {28'd0, exp_en});
            check($sformatf("onehot c%0d", c), {31'd0, ($countones(bus_a.update_en) <= 1)}, 32'd1);
            check($sformatf("done c%0d", c), {31'd0, bus_a.done}, {31'd0, (c == 72)});
            bus_a.start = (c == 30) || (c == 73);
            @(negedge clk);
        end
        bus_a.start = 1'b0;

        for (int i = 0; i < vec_a.size(); i++) begin
            check_vec("full", vec_a[i]);
        end

        // Back-to-back run accepted: I_0 reloads from 15 to 13.
        check("b2b busy", {31'd0, bus_a.busy}, 32'd1);
        check("b2b I_0 reload", {28'd0, bus_a.I_0}, 32'd13);

        // Abort one cycle after the 5th pulse (pulse 4 at c=14).
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 2)  check("abort run pulse0", {28'd0, bus_a.update_en}, 32'd1);
            if (c == 14) check("abort run pulse4", {28'd0, bus_a.update_en}, 32'd1);
        end
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        check("abort busy", {31'd0, bus_a.busy}, 32'd0);
        check("abort update_en", {28'd0, bus_a.update_en}, 32'd0);
        check("abort done", {31'd0, bus_a.done}, 32'd0);
        check("abort I_0", {28'd0, bus_a.I_0}, 32'd13);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus_a.update_en !== 4'b0000 || bus_a.done !== 1'b0 ||
                bus_a.busy !== 1'b0 || bus_a.I_0 !== 4'd13) bad++;
        end
        check("abort quiet", bad, 32'd0);

        // Fresh start after abort restarts at bit0.
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart pulse0", {28'd0, bus_a.update_en}, 32'd1);
        check("restart I_0", {28'd0, bus_a.I_0}, 32'd13);
        repeat (3) @(negedge clk);
        check("restart pulse1", {28'd0, bus_a.update_en}, 32'd2);
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        check("abort2 busy", {31'd0, bus_a.busy}, 32'd0);

        // start and abort together in IDLE: no run.
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bad = 0;
        repeat (10) begin
            if (bus_a.busy !== 1'b0 || bus_a.update_en !== 4'b0000) bad++;
            @(negedge clk);
        end
        check("start+abort no run", bad, 32'd0);

        // Reset during an UPDATE (pulse 8, I_0=14) acts immediately.
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (26) @(negedge clk);
        check("pre-reset pulse8", {28'd0, bus_a.update_en}, 32'd1);
        check("pre-reset I_0", {28'd0, bus_a.I_0}, 32'd14);
        #1 rst_n = 1'b0;
        #1;
        check("async reset update_en", {28'd0, bus_a.update_en}, 32'd0);
        check("async reset busy", {31'd0, bus_a.busy}, 32'd0);
        check("async reset I_0", {28'd0, bus_a.I_0}, 32'd13);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.update_en !== 4'b0000) bad++;
        end
        check("post-reset quiet", bad, 32'd0);

        // Degenerate range run.
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cap_en[c]   = {2'b00, bus_b.update_en};
            cap_i0[c]   = bus_b.I_0;
            cap_busy[c] = bus_b.busy;
            cap_done[c] = bus_b.done;
            @(negedge clk);
        end
        for (int i = 0; i < vec_b.size(); i++) begin
            check_vec("degen", vec_b[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
